// File: rtl/mem_arbiter_if.sv
// Request, response and ram-side signals of the two-port memory arbiter.
// slave is the arbiter's view; master is the view of requesters plus ram.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic        if_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic        d_err;
  logic [31:0] rdata;
  logic [31:0] mem_r_addr;
  logic [31:0] mem_w_addr;
  logic [31:0] mem_w_line;
  logic [31:0] mem_r_line;
  logic        mem_read;
  logic        mem_write;
  logic        mem_rrdy;
  logic        mem_wrdy;
  logic        mem_exc;
  logic        busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata,
    input  mem_r_line, mem_rrdy, mem_wrdy, mem_exc,
    output if_ack, if_err, d_ack, d_err, rdata,
    output mem_r_addr, mem_w_addr, mem_w_line, mem_read, mem_write, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata,
    output mem_r_line, mem_rrdy, mem_wrdy, mem_exc,
    input  if_ack, if_err, d_ack, d_err, rdata,
    input  mem_r_addr, mem_w_addr, mem_w_line, mem_read, mem_write, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch / load-store arbiter and sequencer for the single-ported ram.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin grant; otherwise data has fixed priority.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TW      = 8
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  localparam logic [TW-1:0] TimeoutCnt = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    StIdle, StIssue, StWaitBusy, StWaitDone, StDone, StErr
  } state_e;

  state_e        state_q;
  logic          gnt_data_q;
  logic          we_q;
  logic [TW-1:0] timer_q;
  logic          if_ack_q, if_err_q, d_ack_q, d_err_q;
  logic [31:0]   rdata_q, mem_r_addr_q, mem_w_addr_q, mem_w_line_q;
  logic          mem_read_q, mem_write_q, busy_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic          last_data_q;
`endif

  logic win_data, rdy, to_hit, abort, complete;

  always_comb begin
    win_data = bus.d_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (bus.if_req && bus.d_req) win_data = !last_data_q;
`endif
    rdy      = we_q ? bus.mem_wrdy : bus.mem_rrdy;
    to_hit   = (timer_q == TimeoutCnt);
    abort    = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      // Exception beats ready; ready beats the timer.
      StWaitBusy: abort = bus.mem_exc || (rdy && to_hit);
      StWaitDone: begin
        abort    = bus.mem_exc || (!rdy && to_hit);
        complete = !bus.mem_exc && rdy;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      gnt_data_q   <= 1'b0;
      we_q         <= 1'b0;
      timer_q      <= '0;
      if_ack_q     <= 1'b0;
      if_err_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      d_err_q      <= 1'b0;
      rdata_q      <= '0;
      mem_r_addr_q <= '0;
      mem_w_addr_q <= '0;
      mem_w_line_q <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_data_q  <= 1'b0;
`endif
    end else begin
      if_ack_q <= 1'b0;
      if_err_q <= 1'b0;
      d_ack_q  <= 1'b0;
      d_err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.if_req || bus.d_req) begin
            gnt_data_q <= win_data;
            busy_q     <= 1'b1;
            state_q    <= StIssue;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_data_q <= win_data;
`endif
            if (win_data && bus.d_we) begin
              we_q         <= 1'b1;
              mem_w_addr_q <= bus.d_addr;
              mem_w_line_q <= bus.d_wdata;
              mem_write_q  <= 1'b1;
            end else begin
              we_q         <= 1'b0;
              mem_r_addr_q <= win_data ? bus.d_addr : bus.if_addr;
              mem_read_q   <= 1'b1;
            end
          end
        end
        StIssue: begin
          timer_q <= '0;
          state_q <= StWaitBusy;
        end
        StWaitBusy: begin
          timer_q <= timer_q + 1'b1;
          if (!rdy) begin
            timer_q <= '0;
            state_q <= StWaitDone;
          end
        end
        StWaitDone: timer_q <= timer_q + 1'b1;
        StDone, StErr: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
      // Transaction end overrides the wait-state bookkeeping above.
      if (abort || complete) begin
        mem_read_q  <= 1'b0;
        mem_write_q <= 1'b0;
        if_ack_q    <= !gnt_data_q;
        d_ack_q     <= gnt_data_q;
        if_err_q    <= !gnt_data_q && abort;
        d_err_q     <= gnt_data_q && abort;
        state_q     <= abort ? StErr : StDone;
        if (complete && !we_q) rdata_q <= bus.mem_r_line;
      end
    end
  end

  assign bus.if_ack     = if_ack_q;
  assign bus.if_err     = if_err_q;
  assign bus.d_ack      = d_ack_q;
  assign bus.d_err      = d_err_q;
  assign bus.rdata      = rdata_q;
  assign bus.mem_r_addr = mem_r_addr_q;
  assign bus.mem_w_addr = mem_w_addr_q;
  assign bus.mem_w_line = mem_w_line_q;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level model plus directed vectors.
module tb_mem_arbiter;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  mem_arbiter_if bus();

  mem_arbiter #(.TIMEOUT(TO), .TW(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Ram behaviour, indexed by cycles since the strobe rose (ISSUE cycle = 0):
  // ready low for cycles [ram_a, ram_a+ram_b), exception pulse at cycle ram_e.
  int          ram_a = 1;
  int          ram_b = 1;
  int          ram_e = -1;
  logic [31:0] ram_line = 32'h0;
  int          cyc = -1;
  logic        pat;

  always @(negedge clk) begin
    if (bus.mem_read || bus.mem_write) cyc = cyc + 1;
    else cyc = -1;
    pat = !(cyc >= ram_a && cyc < ram_a + ram_b);
    bus.mem_rrdy   = bus.mem_read ? pat : 1'b1;
    bus.mem_wrdy   = bus.mem_write ? pat : 1'b1;
    bus.mem_exc    = (ram_e >= 0 && cyc == ram_e);
    bus.mem_r_line = (pat && cyc >= ram_a) ? ram_line : ~ram_line;
  end

  // Cycle on which the ram wait ends, encoded as 2*cycle + err.
  function automatic int outcome(input int a, input int b, input int e);
    int c;
    int err;
    if (b > 0 && a <= TO + 1) begin
      if (b <= TO + 1) begin c = a + b; err = 0; end
      else begin c = a + TO + 1; err = 1; end
    end else begin
      c = TO + 1; err = 1;
    end
    if (e >= 1 && e <= c) begin c = e; err = 1; end
    return 2 * c + err;
  endfunction

  int          mk = -1;
  int          m_cend = 0;
  logic        m_d = 1'b0, m_we = 1'b0, m_err = 1'b0, m_last_d = 1'b0;
  logic [31:0] m_line = '0, m_rdata = '0, m_raddr = '0, m_waddr = '0, m_wline = '0;

  always @(posedge clk or posedge rst) begin : model
    logic w;
    if (rst) begin
      mk       <= -1;
      m_last_d <= 1'b0;
      m_rdata  <= '0;
      m_raddr  <= '0;
      m_waddr  <= '0;
      m_wline  <= '0;
    end else if (mk < 0) begin
      if (bus.if_req || bus.d_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        w = (bus.if_req && bus.d_req) ? !m_last_d : bus.d_req;
`else
        w = bus.d_req;
`endif
        m_last_d <= w;
        m_d      <= w;
        m_we     <= w && bus.d_we;
        if (w && bus.d_we) begin
          m_waddr <= bus.d_addr;
          m_wline <= bus.d_wdata;
        end else begin
          m_raddr <= w ? bus.d_addr : bus.if_addr;
        end
        m_line <= ram_line;
        m_cend <= outcome(ram_a, ram_b, ram_e) / 2;
        m_err  <= (outcome(ram_a, ram_b, ram_e) % 2) == 1;
        mk     <= 0;
      end
    end else if (mk == m_cend + 1) begin
      mk <= -1;
    end else begin
      mk <= mk + 1;
      if (mk + 1 == m_cend + 1 && !m_err && !m_we) m_rdata <= m_line;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check1("busy", bus.busy, mk >= 0);
      check1("mem_read", bus.mem_read, mk >= 0 && mk <= m_cend && !m_we);
      check1("mem_write", bus.mem_write, mk >= 0 && mk <= m_cend && m_we);
      check1("if_ack", bus.if_ack, mk == m_cend + 1 && !m_d);
      check1("d_ack", bus.d_ack, mk == m_cend + 1 && m_d);
      check1("if_err", bus.if_err, mk == m_cend + 1 && !m_d && m_err);
      check1("d_err", bus.d_err, mk == m_cend + 1 && m_d && m_err);
      check32("rdata", bus.rdata, m_rdata);
      check32("mem_r_addr", bus.mem_r_addr, m_raddr);
      check32("mem_w_addr", bus.mem_w_addr, m_waddr);
      check32("mem_w_line", bus.mem_w_line, m_wline);
    end
  end

  task automatic run_txn(input string name, input bit dport, input bit we,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] line, input int a, input int b, input int e,
                         input int exp_n, input bit exp_err, output bit seen_rd);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    seen_rd = 1'b0;
    @(negedge clk);
    ram_a = a;
    ram_b = b;
    ram_e = e;
    ram_line = line;
    if (dport) begin
      bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      if (bus.mem_read) seen_rd = 1'b1;
      if (bus.if_ack || bus.d_ack) got = 1'b1;
    end
    check32({name, " ack cycle"}, n, exp_n);
    check1({name, " port"}, bus.d_ack, dport);
    check1({name, " err"}, bus.if_err || bus.d_err, exp_err);
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit          rd;
    int          n, acks, if_cnt;
    logic [3:0]  g;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    repeat (3) @(negedge clk);
    check1("reset busy", bus.busy, 1'b0);
    check1("reset mem_read", bus.mem_read, 1'b0);
    check1("reset if_ack", bus.if_ack, 1'b0);
    check32("reset rdata", bus.rdata, 32'h0);
    rst = 1'b0;
    cmp_en = 1'b1;

    run_txn("fetch", 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEAF, 1, 1, -1, 4, 1'b0, rd);
    check32("fetch rdata", bus.rdata, 32'hDEADBEAF);

    run_txn("store", 1'b1, 1'b1, 32'h10, 32'h35942, 32'h0BAD0BAD, 2, 3, -1, 7, 1'b0, rd);
    check32("store w_addr", bus.mem_w_addr, 32'h10);
    check32("store w_line", bus.mem_w_line, 32'h35942);
    check1("store no read", rd, 1'b0);
    check32("store rdata kept", bus.rdata, 32'hDEADBEAF);

    run_txn("exception", 1'b1, 1'b0, 32'h44, 32'h0, 32'h12345678, 1, 5, 2, 4, 1'b1, rd);
    check1("exception strobe low", bus.mem_read, 1'b0);
    check32("exception rdata kept", bus.rdata, 32'hDEADBEAF);

    run_txn("timeout", 1'b0, 1'b0, 32'h80, 32'h0, 32'h55AA55AA, 1, 0, -1, 7, 1'b1, rd);
    @(negedge clk);
    check1("timeout idle busy", bus.busy, 1'b0);

    // Both ports hold their requests across four transactions.
    @(negedge clk);
    ram_a = 1; ram_b = 1; ram_e = -1; ram_line = 32'hCAFE0001;
    bus.if_req = 1'b1; bus.if_addr = 32'h30;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h20;
    acks = 0; n = 0; if_cnt = 0; g = '0;
    while (acks < 4 && n < 100) begin
      @(negedge clk);
      n++;
      if (bus.if_ack || bus.d_ack) begin
        g = {g[2:0], bus.d_ack};
        acks++;
        if (bus.if_ack) if_cnt++;
      end
    end
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    check32("contention cycles", n, 19);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    check32("contention order", {28'h0, g}, 32'hA);
    check32("contention fetch acks", if_cnt, 2);
`else
    check32("contention order", {28'h0, g}, 32'hF);
    check32("contention fetch acks", if_cnt, 0);
`endif

    // Reset in the middle of a long WAIT_DONE.
    @(negedge clk);
    ram_a = 1; ram_b = 10; ram_e = -1; ram_line = 32'h77777777;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h50;
    n = 0;
    while (mk < 2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check1("pre-reset read high", bus.mem_read, 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check1("async reset mem_read", bus.mem_read, 1'b0);
    check1("async reset busy", bus.busy, 1'b0);
    bus.d_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.if_ack || bus.d_ack) acks++;
    end
    check32("no ack after reset", acks, 0);

    run_txn("post-reset fetch", 1'b0, 1'b0, 32'h64, 32'h0, 32'h0F0F1234, 2, 3, -1, 7, 1'b0, rd);
    check32("post-reset rdata", bus.rdata, 32'h0F0F1234);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
